// File: rtl/branch_resolve.sv
// branch_resolve: fetch/execute sequencer that owns the PC and resolves
// rv32i branch, jal and jalr targets.  The FSM is FETCH -> EXEC -> FETCH,
// with an absorbing TRAP state for misaligned targets and fetch timeouts.
// Optional branch statistics are built when BRANCH_STATS_EN is defined;
// otherwise br_count/br_taken_count are tied to zero.
module branch_resolve #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0060,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic        instr_done,
    input  logic [6:0]  opcode,
    input  logic        br_en,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        trap,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);

    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    // Counter value seen during the last FETCH cycle allowed before trapping.
    localparam logic [31:0] TMO_LAST = 32'(RESP_TIMEOUT - 1);
    localparam bit          TMO_EN   = (RESP_TIMEOUT != 0);

    typedef enum logic [1:0] {FETCH, EXEC, TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] target;
    logic        nonseq;
    logic        misaligned;

    // Next-PC candidate; nonseq marks targets that are not the fall-through.
    always_comb begin
        target = pc_q + 32'd4;
        nonseq = 1'b0;
        case (opcode)
            OP_BR: begin
                if (br_en) begin
                    target = pc_q + imm;
                    nonseq = 1'b1;
                end
            end
            OP_JAL: begin
                target = pc_q + imm;
                nonseq = 1'b1;
            end
            OP_JALR: begin
                target = (rs1_data + imm) & ~32'h1;
                nonseq = 1'b1;
            end
            default: ;
        endcase
        misaligned = (target[1:0] != 2'b00);
    end

    // Next-state logic: fetch handshake with timeout, PC update in EXEC, sticky trap.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        tmo_d      = 32'd0;
        case (state_q)
            FETCH: begin
                // A response in the timeout cycle still wins over the trap.
                if (imem_resp) begin
                    state_d = EXEC;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = TRAP;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            EXEC: begin
                if (instr_done) begin
                    if (misaligned) begin
                        state_d = TRAP;
                    end else begin
                        pc_d       = target;
                        redirect_d = nonseq;
                        state_d    = FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    // Core state registers; reset forces a fresh fetch from RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            tmo_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            tmo_q      <= tmo_d;
        end
    end

    assign imem_read    = (state_q == FETCH);
    assign trap         = (state_q == TRAP);
    assign pc           = pc_q;
    assign imem_address = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign redirect     = redirect_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] br_taken_count_q, br_taken_count_d;

    // Count branches only when the PC actually updates (not on a trapping target).
    always_comb begin
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if ((state_q == EXEC) && instr_done && !misaligned && (opcode == OP_BR)) begin
            br_count_d = br_count_q + 32'd1;
            if (br_en) begin
                br_taken_count_d = br_taken_count_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q       <= 32'd0;
            br_taken_count_q <= 32'd0;
        end else begin
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;
`else
    assign br_count       = 32'd0;
    assign br_taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: scenario tasks plus randomized instruction
// streams checked against a transaction-level PC/statistics model.
module tb_branch_resolve;

    localparam logic [31:0] RST_PC = 32'h0000_0060;
    localparam int unsigned TMO    = 4;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_ALU  = 7'b0110011;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp = 1'b0;
    logic        instr_done = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        br_en = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] pc, pc_plus4;
    logic        redirect, trap;
    logic [31:0] br_count, br_taken_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_redirect;
    logic        m_trap;
    logic [31:0] m_br, m_tk;

    branch_resolve #(.RESET_PC(RST_PC), .RESP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .instr_done(instr_done), .opcode(opcode), .br_en(br_en),
        .imm(imm), .rs1_data(rs1_data), .pc(pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .trap(trap), .br_count(br_count), .br_taken_count(br_taken_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc !== RST_PC || imem_read !== 1'b1 || trap !== 1'b0 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: pc=%h read=%b trap=%b redir=%b want pc=%h read=1 trap=0 redir=0",
                     pc, imem_read, trap, redirect, RST_PC);
        end
        n_cmp++;
        if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stats: br=%0d taken=%0d want 0/0", br_count, br_taken_count);
        end
        imem_resp  = 1'b1;
        instr_done = 1'b1;
        step();
        step();
        imem_resp  = 1'b0;
        instr_done = 1'b0;
        rst_n = 1'b1;
        m_pc = RST_PC; m_redirect = 1'b0; m_trap = 1'b0; m_br = 32'd0; m_tk = 32'd0;
    endtask

    // Fetch phase: response arrives after 'delay' idle FETCH cycles.
    task automatic do_fetch(input int delay, input string tag);
        for (int i = 0; i <= delay; i++) begin
            n_cmp++;
            if (imem_read !== 1'b1 || imem_address !== m_pc || pc !== m_pc || trap !== 1'b0) begin
                n_err++;
                $display("FAIL %s_fetch: read=%b addr=%h pc=%h trap=%b want read=1 addr=pc=%h trap=0",
                         tag, imem_read, imem_address, pc, trap, m_pc);
            end
            n_cmp++;
            if (redirect !== m_redirect) begin
                n_err++;
                $display("FAIL %s_redirect: got %b want %b", tag, redirect, m_redirect);
            end
            instr_done = 1'($urandom);
            opcode     = 7'($urandom);
            imem_resp  = (i == delay);
            step();
            m_redirect = 1'b0;
            imem_resp  = 1'b0;
        end
        instr_done = 1'b0;
        n_cmp++;
        if (imem_read !== 1'b0 || trap !== 1'b0 || pc !== m_pc) begin
            n_err++;
            $display("FAIL %s_to_exec: read=%b trap=%b pc=%h want read=0 trap=0 pc=%h",
                     tag, imem_read, trap, pc, m_pc);
        end
    endtask

    // Execute phase: idle 'wt' cycles then complete the instruction.
    task automatic do_exec(input logic [6:0] op, input logic be, input logic [31:0] im,
                           input logic [31:0] rs1, input int wt, input string tag);
        logic [31:0] tgt;
        logic        ns;
        for (int i = 0; i < wt; i++) begin
            imem_resp = 1'($urandom);
            opcode    = 7'($urandom);
            step();
            imem_resp = 1'b0;
            n_cmp++;
            if (imem_read !== 1'b0 || pc !== m_pc || redirect !== 1'b0) begin
                n_err++;
                $display("FAIL %s_exec_wait: read=%b pc=%h redir=%b want 0/%h/0",
                         tag, imem_read, pc, redirect, m_pc);
            end
        end
        opcode = op; br_en = be; imm = im; rs1_data = rs1;
        instr_done = 1'b1;
        imem_resp  = 1'($urandom);
        if (op == OP_JAL || (op == OP_BR && be)) begin
            tgt = m_pc + im; ns = 1'b1;
        end else if (op == OP_JALR) begin
            tgt = rs1 + im;
            if (tgt % 2 == 1) tgt = tgt - 32'd1;
            ns = 1'b1;
        end else begin
            tgt = m_pc + 32'd4; ns = 1'b0;
        end
        step();
        instr_done = 1'b0;
        imem_resp  = 1'b0;
        if (tgt % 4 != 0) begin
            m_trap = 1'b1; m_redirect = 1'b0;
        end else begin
            m_pc = tgt; m_redirect = ns;
            if (op == OP_BR) begin
                m_br = m_br + 32'd1;
                if (be) m_tk = m_tk + 32'd1;
            end
        end
        n_cmp++;
        if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || imem_address !== m_pc) begin
            n_err++;
            $display("FAIL %s_pc: pc=%h pc4=%h addr=%h want pc=%h", tag, pc, pc_plus4, imem_address, m_pc);
        end
        n_cmp++;
        if (trap !== m_trap || redirect !== m_redirect || imem_read !== !m_trap) begin
            n_err++;
            $display("FAIL %s_ctl: trap=%b redir=%b read=%b want %b/%b/%b",
                     tag, trap, redirect, imem_read, m_trap, m_redirect, !m_trap);
        end
        n_cmp++;
        if (br_count !== (STATS ? m_br : 32'd0) || br_taken_count !== (STATS ? m_tk : 32'd0)) begin
            n_err++;
            $display("FAIL %s_stats: br=%0d taken=%0d want %0d/%0d", tag, br_count, br_taken_count,
                     STATS ? m_br : 32'd0, STATS ? m_tk : 32'd0);
        end
    endtask

    // Random inputs in TRAP must not move anything.
    task automatic hold_trap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            imem_resp = 1'($urandom); instr_done = 1'($urandom); opcode = 7'($urandom);
            br_en = 1'($urandom); imm = $urandom; rs1_data = $urandom;
            step();
            n_cmp++;
            if (trap !== 1'b1 || imem_read !== 1'b0 || pc !== m_pc || redirect !== 1'b0) begin
                n_err++;
                $display("FAIL %s_trap_hold: trap=%b read=%b pc=%h redir=%b want 1/0/%h/0",
                         tag, trap, imem_read, pc, redirect, m_pc);
            end
        end
        imem_resp = 1'b0; instr_done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (pc !== RST_PC || imem_read !== 1'b1 || pc_plus4 !== RST_PC + 32'd4) begin
            n_err++;
            $display("FAIL reset_release: pc=%h read=%b pc4=%h want %h/1/%h", pc, imem_read, pc_plus4,
                     RST_PC, RST_PC + 32'd4);
        end
    endtask

    task automatic test_fetch_latency();
        apply_reset();
        do_fetch(2, "latency");
        do_exec(OP_ALU, 1'b0, 32'd0, 32'd0, 1, "latency");
    endtask

    task automatic test_branch();
        apply_reset();
        do_fetch(0, "br");
        do_exec(OP_JAL, 1'b0, 32'h100 - m_pc, 32'd0, 0, "br_jal");
        do_fetch(1, "br");
        do_exec(OP_BR, 1'b1, 32'hFFFF_FFF8, 32'd0, 0, "br_taken");
        n_cmp++;
        if (pc !== 32'h0000_00F8 || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL br_taken_value: pc=%h redir=%b want 000000f8/1", pc, redirect);
        end
        do_fetch(0, "br_f8");
        do_exec(OP_JAL, 1'b0, 32'd8, 32'd0, 0, "br_back");
        do_fetch(0, "br");
        do_exec(OP_BR, 1'b0, 32'hFFFF_FFF8, 32'd0, 2, "br_not_taken");
        n_cmp++;
        if (pc !== 32'h0000_0104 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL br_nt_value: pc=%h redir=%b want 00000104/0", pc, redirect);
        end
        do_fetch(0, "br");
        // A jump whose target happens to be pc+4 is still a redirect.
        do_exec(OP_JAL, 1'b0, 32'd4, 32'd0, 0, "br_jal4");
        do_fetch(0, "br");
    endtask

    task automatic test_jalr_trap();
        apply_reset();
        do_fetch(0, "jalr");
        do_exec(OP_JALR, 1'b0, 32'd0, 32'h201, 0, "jalr_ok");
        n_cmp++;
        if (pc !== 32'h0000_0200 || trap !== 1'b0) begin
            n_err++;
            $display("FAIL jalr_ok_value: pc=%h trap=%b want 00000200/0", pc, trap);
        end
        do_fetch(1, "jalr");
        do_exec(OP_JALR, 1'b0, 32'd0, 32'h203, 0, "jalr_mis");
        n_cmp++;
        if (pc !== 32'h0000_0200 || trap !== 1'b1) begin
            n_err++;
            $display("FAIL jalr_mis_value: pc=%h trap=%b want 00000200/1", pc, trap);
        end
        hold_trap(6, "jalr");
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (trap !== 1'b0 || imem_read !== 1'b1) begin
                n_err++;
                $display("FAIL tmo_early_%0d: trap=%b read=%b want 0/1", i, trap, imem_read);
            end
        end
        step();
        m_trap = 1'b1;
        n_cmp++;
        if (trap !== 1'b1 || imem_read !== 1'b0 || pc !== RST_PC) begin
            n_err++;
            $display("FAIL tmo_fire: trap=%b read=%b pc=%h want 1/0/%h", trap, imem_read, pc, RST_PC);
        end
        hold_trap(3, "tmo");
        apply_reset();
        do_fetch(3, "tmo_last");
        do_exec(OP_ALU, 1'b0, 32'd0, 32'd0, 0, "tmo_last");
        // Reset asserted mid-fetch abandons it and restarts at RESET_PC.
        do_fetch(0, "tmo");
        do_exec(OP_JAL, 1'b0, 32'h40, 32'd0, 0, "tmo_jal");
        step();
        apply_reset();
        do_fetch(1, "tmo_restart");
    endtask

    task automatic test_reset_in_trap();
        apply_reset();
        do_fetch(0, "rtrap");
        do_exec(OP_JAL, 1'b0, 32'h400 - m_pc, 32'd0, 0, "rtrap_jal");
        do_fetch(0, "rtrap");
        do_exec(OP_JALR, 1'b0, 32'd0, 32'h403, 0, "rtrap_mis");
        hold_trap(2, "rtrap");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc !== RST_PC || trap !== 1'b0 || imem_read !== 1'b1) begin
            n_err++;
            $display("FAIL rtrap_async: pc=%h trap=%b read=%b want %h/0/1", pc, trap, imem_read, RST_PC);
        end
        step();
        rst_n = 1'b1;
        m_pc = RST_PC; m_trap = 1'b0; m_redirect = 1'b0; m_br = 32'd0; m_tk = 32'd0;
        do_fetch(0, "rtrap_after");
    endtask

    task automatic test_wrap();
        apply_reset();
        do_fetch(0, "wrap");
        do_exec(OP_JAL, 1'b0, 32'hFFFF_FFFC - m_pc, 32'd0, 0, "wrap_jal");
        do_fetch(0, "wrap");
        do_exec(OP_ALU, 1'b0, 32'd0, 32'd0, 0, "wrap_seq");
        n_cmp++;
        if (pc !== 32'd0 || trap !== 1'b0 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_value: pc=%h trap=%b redir=%b want 0/0/0", pc, trap, redirect);
        end
        do_fetch(0, "wrap_zero");
    endtask

    task automatic test_stats();
        logic [4:0] taken = 5'b10110;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            do_fetch(i % 3, "stats");
            if (i < 5) do_exec(OP_BR, taken[i], 32'h10, 32'd0, i % 2, "stats_br");
            else       do_exec(OP_JAL, 1'b0, 32'h20, 32'd0, 0, "stats_jal");
        end
        n_cmp++;
        if (br_count !== (STATS ? 32'd5 : 32'd0) || br_taken_count !== (STATS ? 32'd3 : 32'd0)) begin
            n_err++;
            $display("FAIL stats_total: br=%0d taken=%0d want %0d/%0d", br_count, br_taken_count,
                     STATS ? 5 : 0, STATS ? 3 : 0);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops[4];
        logic [6:0]  op;
        logic [31:0] im, rs1;
        logic [11:0] r;
        ops[0] = OP_BR; ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = OP_ALU;
        apply_reset();
        for (int n = 0; n < 150; n++) begin
            do_fetch($urandom_range(0, 3), "rnd");
            op  = ops[$urandom_range(0, 3)];
            r   = 12'($urandom);
            im  = {{20{r[11]}}, r[11:2], 2'b00};
            if ($urandom_range(0, 7) == 0) im[1:0] = 2'($urandom);
            rs1 = {$urandom_range(0, 32'h3FFF), 2'($urandom_range(0, 1) * 2'd0 + 2'($urandom))};
            if ($urandom_range(0, 3) != 0) rs1[1] = 1'b0;
            do_exec(op, 1'($urandom), im, rs1, $urandom_range(0, 3), "rnd");
            if (m_trap) begin
                hold_trap(2, "rnd");
                apply_reset();
            end
        end
    endtask

    initial begin
        m_pc = RST_PC; m_redirect = 1'b0; m_trap = 1'b0; m_br = 32'd0; m_tk = 32'd0;
        test_reset();
        test_fetch_latency();
        test_branch();
        test_jalr_trap();
        test_timeout();
        test_reset_in_trap();
        test_wrap();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0060: PC value loaded on reset.
REQ-002 Parameter RESP_TIMEOUT, default 255: cycles FETCH waits for imem_resp before trapping; 0 disables the timeout.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_read  output  1  instruction fetch request; held high until imem_resp.
REQ-006 imem_address  output  32  fetch address; equals pc.
REQ-007 imem_resp  input  1  fetch complete; 1-cycle pulse.
REQ-008 instr_done  input  1  execute stage has finished the current instruction; PC may advance.
REQ-009 opcode  input  7  rv32i opcode of the current instruction (op_br, op_jal, op_jalr, other).
REQ-010 br_en  input  1  branch-taken flag from the branch comparator.
REQ-011 imm  input  32  sign-extended immediate (B/J/I format, per opcode).
REQ-012 rs1_data  input  32  rs1 value, used for jalr.
REQ-013 pc  output  32  current PC.
REQ-014 pc_plus4  output  32  pc + 4, the jal/jalr link value.
REQ-015 redirect  output  1  1-cycle pulse: the last PC update was a non-sequential target.
REQ-016 trap  output  1  sticky fault: misaligned target or fetch timeout.
REQ-017 br_count, br_taken_count  output  32 each  branch statistics (see Configuration).

Function
REQ-018 The FSM SHALL have exactly three states: FETCH, EXEC and TRAP.
REQ-019 FETCH: imem_read=1; on imem_resp=1 -> EXEC next cycle; instr_done ignored.
REQ-020 EXEC: imem_read=0; imem_resp ignored; on instr_done=1 the PC updates at that edge, then -> FETCH (or -> TRAP per REQ-024).
REQ-021 Next-PC selection, all sums modulo 2^32:
- op_br with br_en=1 -> pc+imm.
- op_jal -> pc+imm.
- op_jalr -> (rs1_data+imm) & ~32'h1.
- otherwise, including op_br with br_en=0 -> pc+4.
REQ-022 redirect SHALL be 1 in the cycle after an update that used a non-sequential target, and 0 otherwise, even if that target equals pc+4.
REQ-023 pc SHALL be 0xFFFF_FFFC followed by +4 wraps to 0x0000_0000 with no trap.
REQ-024 A target with bits [1:0] != 0 SHALL leave pc unchanged, set trap=1, and move to TRAP.
REQ-025 In FETCH, a cycle counter SHALL count cycles since entry; when it reaches RESP_TIMEOUT without imem_resp (RESP_TIMEOUT != 0), the block SHALL set trap=1 and move to TRAP.
REQ-026 If imem_resp arrives in the same cycle the counter reaches RESP_TIMEOUT, the response SHALL win (-> EXEC).
REQ-027 TRAP SHALL be absorbing until reset: imem_read=0, pc frozen, all inputs ignored.
REQ-028 pc_plus4 SHALL be combinational from pc at all times.
REQ-029 The block SHALL never issue a fetch to a new PC while the previous fetch is outstanding; pc SHALL be stable whenever imem_read=1.

Reset
REQ-030 While rst_n=0, all outputs SHALL be forced immediately and asynchronously to reset values:
- pc=RESET_PC, state=FETCH, imem_read=1, redirect=0, trap=0.
- br_count=0, br_taken_count=0; timeout counter=0.
REQ-031 A reset asserted mid-fetch or in TRAP SHALL abandon the fetch and clear trap; the first fetch after release SHALL be to RESET_PC.
REQ-032 Reset SHALL be released synchronously to clk by the system; the block SHALL take no action in the edge coincident with release beyond holding reset values.

Configuration
REQ-033 Macro BRANCH_STATS_EN defined:
- br_count increments on each EXEC update with opcode=op_br.
- br_taken_count increments when that branch also has br_en=1.
- Both counters wrap modulo 2^32 and do not count in TRAP.
REQ-034 Macro BRANCH_STATS_EN undefined: both ports SHALL remain present and be driven constant 0, with no counter registers present.

Verification
REQ-035 Reset release with RESET_PC=0x60 and imem_resp after 3 cycles -> imem_address=0x60 throughout, EXEC on the 4th cycle, imem_read=0.
REQ-036 pc=0x100, op_br, br_en=1, imm=-8, instr_done -> pc=0xF8, redirect=1 for one cycle, next fetch at 0xF8; with br_en=0 -> pc=0x104, redirect=0.
REQ-037 op_jalr, rs1_data=0x203, imm=0 -> pc=0x202 -> trap=1, pc unchanged, state TRAP; op_jalr, rs1_data=0x201 -> pc=0x200, no trap.
REQ-038 RESP_TIMEOUT=4, imem_resp never asserted -> trap=1 after 4 FETCH cycles; imem_resp on exactly the 4th cycle -> EXEC, no trap.
REQ-039 With BRANCH_STATS_EN, 5 branches of which 3 taken plus 2 jal -> br_count=5, br_taken_count=3; without the macro both read 0.
REQ-040 rst_n pulsed low while in TRAP with pc=0x400 -> outputs immediately pc=0x60, trap=0, imem_read=1, with no clock edge required.
